// File: rtl/rom_arbiter_pkg.sv
// Shared widths, encodings and defaults for the instruction-ROM arbiter.
// Imported by rom_arbiter and rom_arb_grant.
package rom_arbiter_pkg;

  localparam int INST_ADDR_WIDTH    = 32;
  localparam int INST_DATA_WIDTH    = 32;
  localparam int ROM_LAT_DEFAULT    = 0;
  localparam int MAX_STARVE_DEFAULT = 4;

  // Counter widths cover the legal ranges 0..7 (latency) and 1..15 (starvation).
  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  function automatic logic [STARVE_W-1:0] starve_sat_inc(
    input logic [STARVE_W-1:0] cnt,
    input int                  max_cnt
  );
    return (cnt >= STARVE_W'(max_cnt)) ? STARVE_W'(max_cnt) : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Combinational grant decision: LS has priority unless IF has been starved
// for MAX_STARVE consecutive contended grants.
module rom_arb_grant
  import rom_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = MAX_STARVE_DEFAULT
) (
  input  logic                if_valid_i,
  input  logic                ls_valid_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                grant_if_o,
  output logic                grant_ls_o
);

  logic if_forced;

  assign if_forced  = if_valid_i && (starve_cnt_i == STARVE_W'(MAX_STARVE));
  assign grant_if_o = if_valid_i && (!ls_valid_i || if_forced);
  assign grant_ls_o = ls_valid_i && !if_forced;

endmodule

// File: rtl/rom_arbiter.sv
// Shares one single-port instruction ROM between the IF fetch port and the
// LS read port; one access in flight, response routed back to its owner.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_WIDTH,
  parameter int DATA_W     = INST_DATA_WIDTH,
  parameter int ROM_LAT    = ROM_LAT_DEFAULT,
  parameter int MAX_STARVE = MAX_STARVE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              arb_busy
);

  arb_state_e          state_q;
  owner_e              owner_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                rom_ce_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                if_rsp_valid_q, ls_rsp_valid_q;
  logic [DATA_W-1:0]   if_rsp_data_q, ls_rsp_data_q;
  logic                grant_if, grant_ls, idle;

  assign idle = (state_q == ARB_IDLE);

  rom_arb_grant #(.MAX_STARVE(MAX_STARVE)) u_grant (
    .if_valid_i   (if_req_valid),
    .ls_valid_i   (ls_req_valid),
    .starve_cnt_i (starve_cnt_q),
    .grant_if_o   (grant_if),
    .grant_ls_o   (grant_ls)
  );

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign if_req_ready = !rst && idle && grant_if;
  assign ls_req_ready = !rst && idle && grant_ls;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle) begin
      if (grant_ls && if_req_valid) starve_cnt_d = starve_sat_inc(starve_cnt_q, MAX_STARVE);
      else                          starve_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWN_IF;
      lat_cnt_q      <= '0;
      starve_cnt_q   <= '0;
      rom_ce_q       <= 1'b0;
      rom_addr_q     <= '0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_data_q  <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_if || grant_ls) begin
            state_q    <= ARB_ACCESS;
            owner_q    <= grant_ls ? OWN_LS : OWN_IF;
            rom_addr_q <= grant_ls ? ls_req_addr : if_req_addr;
            lat_cnt_q  <= LAT_W'(ROM_LAT);
            rom_ce_q   <= 1'b1;
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end else begin
            state_q  <= ARB_IDLE;
            rom_ce_q <= 1'b0;
            if (owner_q == OWN_LS) begin
              ls_rsp_data_q  <= rom_data;
              ls_rsp_valid_q <= 1'b1;
            end else begin
              if_rsp_data_q  <= rom_data;
              if_rsp_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign ls_rsp_data  = ls_rsp_data_q;
  assign rom_ce       = rom_ce_q;
  assign rom_addr     = rom_addr_q;
  assign arb_busy     = (state_q == ARB_ACCESS);

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a cycle-count reference model.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int LAT  = 2;
  localparam int MAXS = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, ls_req_valid;
  logic [AW-1:0] if_req_addr, ls_req_addr;
  logic          if_req_ready, ls_req_ready;
  logic          if_rsp_valid, ls_rsp_valid;
  logic [DW-1:0] if_rsp_data, ls_rsp_data;
  logic          rom_ce, arb_busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .MAX_STARVE(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data), .arb_busy(arb_busy)
  );

  // ROM model: data for an address appears LAT cycles after the address.
  logic [DW-1:0] rom_mem [0:255];
  logic [DW-1:0] rom_now;
  logic [DW-1:0] rom_dly [0:LAT-1];
  assign rom_now = rom_mem[rom_addr[9:2]];
  always_ff @(posedge clk) begin
    rom_dly[0] <= rom_now;
    for (int i = 1; i < LAT; i++) rom_dly[i] <= rom_dly[i-1];
  end
  assign rom_data = rom_dly[LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: timing derived from "accept at c, ROM busy c+1..c+1+LAT,
  // response and next grant at c+LAT+2".
  int            cyc;
  int            idle_at;
  int            starve;
  int            acc_start;
  logic [AW-1:0] acc_addr;
  int            rsp_due;
  bit            rsp_ls;
  logic [DW-1:0] rsp_word;
  logic [DW-1:0] exp_if_data, exp_ls_data;
  bit            if_acc, ls_acc;
  bit            obs_if_ready, obs_ls_ready, obs_ls_rsp;
  bit            contention;
  int            ls_run;

  task automatic model_reset();
    idle_at = cyc; starve = 0; acc_start = -1; rsp_due = -1;
    exp_if_data = '0; exp_ls_data = '0;
  endtask

  task automatic tick();
    bit idle, forced, exp_if_rdy, exp_ls_rdy, in_acc, due;
    @(negedge clk);
    idle       = (cyc >= idle_at);
    forced     = if_req_valid && (starve == MAXS);
    exp_if_rdy = idle && if_req_valid && (!ls_req_valid || forced);
    exp_ls_rdy = idle && ls_req_valid && !forced;
    check("if_req_ready", if_req_ready, exp_if_rdy);
    check("ls_req_ready", ls_req_ready, exp_ls_rdy);
    in_acc = (acc_start >= 0) && (cyc > acc_start) && (cyc <= acc_start + 1 + LAT);
    check("rom_ce", rom_ce, in_acc);
    check("arb_busy", arb_busy, in_acc);
    if (in_acc) check("rom_addr", rom_addr, acc_addr);
    due = (rsp_due == cyc);
    if (due && rsp_ls)  exp_ls_data = rsp_word;
    if (due && !rsp_ls) exp_if_data = rsp_word;
    check("if_rsp_valid", if_rsp_valid, due && !rsp_ls);
    check("ls_rsp_valid", ls_rsp_valid, due && rsp_ls);
    check("if_rsp_data", if_rsp_data, exp_if_data);
    check("ls_rsp_data", ls_rsp_data, exp_ls_data);
    obs_if_ready = if_req_ready;
    obs_ls_ready = ls_req_ready;
    obs_ls_rsp   = ls_rsp_valid;
    if (contention) begin
      if (ls_req_ready) ls_run++;
      if (if_req_ready) begin
        check("ls_grants_before_if", ls_run, MAXS);
        ls_run = 0;
      end
    end
    if_acc = exp_if_rdy;
    ls_acc = exp_ls_rdy;
    if (idle) starve = (ls_acc && if_req_valid) ? ((starve + 1 > MAXS) ? MAXS : starve + 1) : 0;
    if (if_acc || ls_acc) begin
      acc_start = cyc;
      idle_at   = cyc + LAT + 2;
      acc_addr  = ls_acc ? ls_req_addr : if_req_addr;
      rsp_due   = cyc + LAT + 2;
      rsp_ls    = ls_acc;
      rsp_word  = rom_mem[acc_addr[9:2]];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ready"}, if_req_ready, 1'b0);
    check({tag, "_ls_ready"}, ls_req_ready, 1'b0);
    check({tag, "_ce"},       rom_ce,       1'b0);
    check({tag, "_addr"},     rom_addr,     '0);
    check({tag, "_busy"},     arb_busy,     1'b0);
    check({tag, "_rspv"},     {if_rsp_valid, ls_rsp_valid}, 2'b00);
    check({tag, "_rspd"},     {if_rsp_data, ls_rsp_data},   '0);
  endtask

  // Issue one request and wait (bounded) until the model sees it accepted.
  task automatic issue(input bit ls, input logic [AW-1:0] a, input string tag);
    int n = 0;
    if (ls) begin ls_req_valid = 1'b1; ls_req_addr = a; end
    else    begin if_req_valid = 1'b1; if_req_addr = a; end
    do begin tick(); n++; end while (!(ls ? ls_acc : if_acc) && n < 20);
    if (!(ls ? ls_acc : if_acc)) check({tag, "_accept_timeout"}, n, 0);
    if (ls) ls_req_valid = 1'b0;
    else    if_req_valid = 1'b0;
  endtask

  int t0, t_if;

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[8] = 32'hDEAD_BEEF;
    rom_mem[9] = 32'h1234_5678;
    contention = 1'b0; ls_run = 0; cyc = 0;

    // Reset with both requesters asserting: nothing may be granted.
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h4;
    ls_req_valid = 1'b1; ls_req_addr = 32'h8;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    #1 rst = 1'b0;
    model_reset();

    // Single IF fetch, then a single LS read.
    issue(1'b0, 32'h0000_0004, "if_single");
    repeat (LAT + 3) tick();
    check("if_word1", if_rsp_data, rom_mem[1]);
    issue(1'b1, 32'h0000_0010, "ls_single");
    repeat (LAT + 3) tick();
    check("ls_word4", ls_rsp_data, rom_mem[4]);

    // Data isolation between the two response registers.
    issue(1'b0, 32'h20, "iso_if");
    repeat (LAT + 3) tick();
    issue(1'b1, 32'h24, "iso_ls");
    repeat (LAT + 3) tick();
    check("iso_if_data_kept", if_rsp_data, 32'hDEAD_BEEF);
    check("iso_ls_data",      ls_rsp_data, 32'h1234_5678);

    // Busy blocking: IF raised during an LS access is taken with the LS response.
    issue(1'b1, 32'h30, "busy_ls");
    t0 = cyc - 1;
    issue(1'b0, 32'h34, "busy_if");
    t_if = cyc - 1;
    check("busy_if_accept_cycle", t_if - t0, LAT + 2);
    check("busy_if_with_ls_rsp", {obs_if_ready, obs_ls_rsp}, 2'b11);
    repeat (LAT + 3) tick();

    // Sustained contention: every IF grant is preceded by MAXS LS grants.
    contention = 1'b1; ls_run = 0;
    if_req_valid = 1'b1; if_req_addr = {$urandom_range(0, 255), 2'b00};
    ls_req_valid = 1'b1; ls_req_addr = {$urandom_range(0, 255), 2'b00};
    repeat (14 * (LAT + 2)) begin
      tick();
      if (if_acc) if_req_addr = {$urandom_range(0, 255), 2'b00};
      if (ls_acc) ls_req_addr = {$urandom_range(0, 255), 2'b00};
    end
    contention = 1'b0;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (LAT + 3) tick();

    // Reset during the second ACCESS cycle: access abandoned, no response.
    issue(1'b0, 32'h8, "rst_mid_if");
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); cyc++;
    #1 rst = 1'b0;
    model_reset();
    repeat (LAT + 4) tick();
    issue(1'b0, 32'hC, "after_rst_if");
    repeat (LAT + 3) tick();
    check("after_rst_word3", if_rsp_data, rom_mem[3]);

    // Randomized traffic, including requesters that withdraw while waiting.
    repeat (600) begin
      tick();
      if (if_acc) if_req_valid = 1'b0;
      if (ls_acc) ls_req_valid = 1'b0;
      if (!if_acc && if_req_valid && $urandom_range(0, 15) == 0) if_req_valid = 1'b0;
      else if (!if_req_valid && $urandom_range(0, 2) == 0) begin
        if_req_valid = 1'b1; if_req_addr = $urandom;
      end
      if (!ls_acc && ls_req_valid && $urandom_range(0, 15) == 0) ls_req_valid = 1'b0;
      else if (!ls_req_valid && $urandom_range(0, 2) == 0) begin
        ls_req_valid = 1'b1; ls_req_addr = $urandom;
      end
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (LAT + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one single-port instruction ROM between two requesters: the IF fetch port and the load/debug read port (LS).
- Sits between `mips_top` and `inst_rom`, and owns `rom_ce`/`rom_addr`.
- Grants one request at a time with LS priority, plus a starvation guard for IF.
- Tolerates an N-cycle ROM read latency and returns data to the requester that owned the access.

Parameters:
- ADDR_W, `INST_ADDR_WIDTH: request and ROM address width.
- DATA_W, `INST_DATA_WIDTH: ROM data width.
- ROM_LAT, 0: ROM cycles from ce/addr valid to data valid. 0 means combinational ROM; legal range 0..7.
- MAX_STARVE, 4: consecutive IF losses allowed before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  ADDR_W  IF byte address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  one-cycle pulse: if_rsp_data updated
- if_rsp_data  out  DATA_W  IF read data
- ls_req_valid  in  1  LS read request
- ls_req_addr  in  ADDR_W  LS byte address
- ls_req_ready  out  1  LS request accepted this cycle
- ls_rsp_valid  out  1  one-cycle pulse: ls_rsp_data updated
- ls_rsp_data  out  DATA_W  LS read data
- rom_ce  out  1  ROM enable
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM read data
- arb_busy  out  1  access in flight (state != IDLE)

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, starve_cnt=0, lat_cnt=0, owner=IF. All outputs are 0, including both rsp_data registers.
- Handshake: a request transfers when valid && ready. Requesters hold valid and addr stable until ready. ready is combinational and only high in IDLE, and only for the winner. The arbiter never deasserts ready while valid is high within that cycle.
- Arbitration, evaluated in IDLE only:
  - LS only → LS wins. IF only → IF wins.
  - Both valid → LS wins, unless starve_cnt == MAX_STARVE, in which case IF wins.
  - starve_cnt increments (saturating at MAX_STARVE) when LS wins while if_req_valid is high.
  - starve_cnt clears when IF wins or if_req_valid is low in IDLE.
- State machine IDLE → ACCESS → IDLE.
  - IDLE, on a grant at edge T0: latch addr into rom_addr, latch owner, load lat_cnt=ROM_LAT, and register rom_ce=1. Go to ACCESS.
  - ACCESS: rom_ce=1 and rom_addr stable. While lat_cnt != 0, decrement.
  - ACCESS, lat_cnt == 0: capture rom_data into the owner's rsp_data register. Pulse the owner's rsp_valid in the next cycle. rom_ce=0, return to IDLE.
- Timing: accept cycle T0; ACCESS spans T1..T1+ROM_LAT; rsp_valid is high at cycle T0+ROM_LAT+2.
- Throughput: the IDLE cycle carrying rsp_valid may accept a new request. Peak rate is one access per ROM_LAT+2 cycles.
- rsp_data holds its last value until that port's next response. The other port's rsp_data is never disturbed.
- Addresses pass through unmodified; word indexing is the ROM's job. No alignment checks.
- Simultaneous events:
  - Requests arriving during ACCESS wait; ready stays low.
  - A requester dropping valid while waiting is legal, and no access is issued for it.
- Reset mid-ACCESS: the access is abandoned, no rsp_valid is generated, and rom_ce drops immediately.

Decomposition:
- Shared package/defines (alongside the `INST_*` width defines):
  - State encoding: ARB_IDLE=1'b0, ARB_ACCESS=1'b1.
  - Owner encoding: OWN_IF=1'b0, OWN_LS=1'b1.
  - Defaults for ROM_LAT and MAX_STARVE.
- Natural sub-module: `rom_arb_grant`, the combinational priority plus starve-counter decision (inputs: both valids, starve_cnt; outputs: grant_if, grant_ls). It is kept separate so it can be unit-tested.
- Everything else stays flat.

Test Plan:
- Reset and single IF (ROM_LAT=0): assert rst mid-run → all outputs 0 within the same cycle. Then if_req addr 0x0000_0004 accepted at T0 → rom_ce=1 and rom_addr=0x4 at T1; if_rsp_valid=1 at T2 with ROM word 1; ls_rsp_valid stays 0.
- Latency (ROM_LAT=3): LS request addr 0x10 → rom_ce high for exactly 4 cycles; ls_rsp_valid at T0+5; ls_rsp_data = ROM word 4.
- Contention (MAX_STARVE=4, ROM_LAT=0): both valid continuously → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF… Each IF grant follows exactly 4 LS grants.
- Busy blocking: IF request raised at T1 while LS is in ACCESS → if_req_ready=0 until IDLE; IF accepted at T2 in the same cycle as ls_rsp_valid.
- Data isolation: IF read returns 0xDEAD_BEEF, then LS read returns 0x1234_5678 → if_rsp_data still 0xDEAD_BEEF.
- Reset mid-ACCESS (ROM_LAT=2): assert rst during the second ACCESS cycle → no rsp_valid pulse; after release, a new IF request completes normally.
